// File: rtl/icache_nway_if.sv
// Fetch-side and memory-controller-side signals of the two-way instruction cache.
interface icache_nway_if;
  logic        rdy;
  logic        full;
  logic        rollback;
  logic        invalidate;
  logic        if_addr_sgn;
  logic [31:0] if_addr;
  logic        if_val_sgn;
  logic [31:0] if_val;
  logic        mc_addr_sgn;
  logic [31:0] mc_addr;
  logic        mc_val_sgn;
  logic [31:0] mc_val;

  modport master (
    output rdy, full, rollback, invalidate, if_addr_sgn, if_addr, mc_val_sgn, mc_val,
    input  if_val_sgn, if_val, mc_addr_sgn, mc_addr
  );

  modport slave (
    input  rdy, full, rollback, invalidate, if_addr_sgn, if_addr, mc_val_sgn, mc_val,
    output if_val_sgn, if_val, mc_addr_sgn, mc_addr
  );
endinterface

// File: rtl/icache_nway.sv
// Two-way set-associative instruction cache with LRU replacement and
// word-by-word line refill from the memory controller.
module icache_nway #(
  parameter int IDX_W  = 6,
  parameter int WORD_W = 2
) (
  input  logic          clk,
  input  logic          rst,
  icache_nway_if.slave  bus
);
  localparam int TAG_W  = 30 - IDX_W - WORD_W;
  localparam int SETS   = 1 << IDX_W;
  localparam int WORDS  = 1 << WORD_W;
  localparam int LINE_W = TAG_W + IDX_W;

  typedef enum logic {IDLE, REFILL} state_t;
  state_t state, state_next;

  logic [SETS-1:0]   valid [2];
  logic [SETS-1:0]   lru;
  logic [TAG_W-1:0]  tag_mem  [2][SETS];
  logic [31:0]       data_mem [2][SETS*WORDS];
  logic              inv_pend;
  logic [LINE_W-1:0] line_q;
  logic              victim_q;
  logic [WORD_W-1:0] cnt;

  logic [IDX_W-1:0]  req_idx, ref_idx;
  logic [TAG_W-1:0]  req_tag, ref_tag;
  logic [WORD_W-1:0] req_word;
  logic              hit0, hit1, hit, victim_sel;
  logic [31:0]       hit_word;
  logic              inv_now, do_inv, req_ok, do_hit, do_miss, mc_write, last;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^bus.if_addr[1:0];

  always_comb begin
    req_word   = bus.if_addr[WORD_W+1:2];
    req_idx    = bus.if_addr[IDX_W+WORD_W+1:WORD_W+2];
    req_tag    = bus.if_addr[31:IDX_W+WORD_W+2];
    ref_idx    = line_q[IDX_W-1:0];
    ref_tag    = line_q[LINE_W-1:IDX_W];
    hit0       = valid[0][req_idx] && (tag_mem[0][req_idx] == req_tag);
    hit1       = valid[1][req_idx] && (tag_mem[1][req_idx] == req_tag);
    hit        = hit0 || hit1;
    hit_word   = data_mem[hit1][{req_idx, req_word}];
    victim_sel = !valid[0][req_idx] ? 1'b0 :
                 !valid[1][req_idx] ? 1'b1 : lru[req_idx];
  end

  // A pending invalidate blocks lookups exactly like a fresh one, so the
  // line completed under it is never delivered before being cleared.
  always_comb begin
    inv_now     = bus.invalidate || inv_pend;
    do_inv      = (state == IDLE) && bus.rdy && inv_now;
    req_ok      = (state == IDLE) && bus.rdy && !bus.rollback && !inv_now && bus.if_addr_sgn;
    do_hit      = req_ok && hit && !bus.full;
    do_miss     = req_ok && !hit;
    mc_write    = (state == REFILL) && bus.rdy && bus.mc_val_sgn;
    last        = mc_write && (cnt == '1);
    state_next  = state;
    if (do_miss) state_next = REFILL;
    if (last)    state_next = IDLE;
    bus.mc_addr_sgn = (state == REFILL) && bus.rdy;
    bus.mc_addr     = {line_q, cnt, 2'b00};
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid[0]       <= '0;
      valid[1]       <= '0;
      lru            <= '0;
      inv_pend       <= 1'b0;
      cnt            <= '0;
      line_q         <= '0;
      victim_q       <= 1'b0;
      bus.if_val_sgn <= 1'b0;
      bus.if_val     <= '0;
    end else begin
      bus.if_val_sgn <= do_hit;
      if (do_hit) begin
        bus.if_val   <= hit_word;
        lru[req_idx] <= hit0;
      end
      if (do_inv)              inv_pend <= 1'b0;
      else if (bus.invalidate) inv_pend <= 1'b1;
      if (do_inv) begin
        valid[0] <= '0;
        valid[1] <= '0;
      end
      // The victim is invalidated up front so an aborted refill never
      // leaves a valid line holding a mix of old and new words.
      if (do_miss) begin
        line_q                       <= bus.if_addr[31:WORD_W+2];
        victim_q                     <= victim_sel;
        cnt                          <= '0;
        valid[victim_sel][req_idx]   <= 1'b0;
      end
      if (mc_write) cnt <= cnt + 1'b1;
      if (last) begin
        valid[victim_q][ref_idx] <= 1'b1;
        lru[ref_idx]             <= ~victim_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && mc_write) data_mem[victim_q][{ref_idx, cnt}] <= bus.mc_val;
    if (!rst && last)     tag_mem[victim_q][ref_idx]         <= ref_tag;
  end
endmodule
